// File: rtl/pwm_out_pkg.sv
// Shared definitions for the pwm_out CSR peripheral.
// Register map, CTRL layout and period geometry.
package pwm_out_pkg;

    localparam logic [4:0] REG_CTRL = 5'd0;
    localparam logic [4:0] REG_DUTY = 5'd1;

    localparam int CTRL_EN  = 7;
    localparam int CTRL_INV = 6;

    localparam int STEPS  = 128;
    localparam int STEP_W = 7;

    // Writable CTRL bits; everything else reads back as zero
    localparam logic [7:0] CTRL_MASK =
        (8'h01 << CTRL_EN) | (8'h01 << CTRL_INV) | 8'h03;

    typedef struct packed {
        logic       en;
        logic       inv;
        logic [3:0] rsvd;
        logic [1:0] presc;
    } ctrl_t;

    typedef enum logic [1:0] {
        SEL_NONE,
        SEL_CTRL,
        SEL_DUTY
    } sel_e;

    function automatic logic [15:0] div_value(
        input logic [15:0] base,
        input logic [1:0]  presc
    );
        return base << {presc, 1'b0};
    endfunction

endpackage

// File: rtl/pwm_out_prescaler.sv
// Step prescaler: divides clk by DIV_BASE << (2*presc).
// Held at zero while stopped; clr restarts the count without a tick.
module pwm_prescaler
    import pwm_out_pkg::*;
#(
    parameter logic [15:0] DIV_BASE = 16'd32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic       clr,
    input  logic [1:0] presc,
    output logic       tick
);

    logic [15:0] count;
    logic [15:0] last;

    assign last = div_value(DIV_BASE, presc) - 16'd1;
    assign tick = run && !clr && (count == last);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (!run || clr || tick) begin
            count <= '0;
        end else begin
            count <= count + 16'd1;
        end
    end

endmodule

// File: rtl/pwm_out.sv
// CSR-programmable 128-step PWM generator with shadowed duty.
// Duty changes land only at the period boundary, so no runt pulses.
module pwm_out
    import pwm_out_pkg::*;
#(
    parameter logic [4:0]  BASE_ADDR = 5'h0,
    parameter logic [15:0] DIV_BASE  = 16'd32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] csr_a,
    input  logic [7:0] csr_di,
    input  logic       csr_we,
    output logic [7:0] csr_do,
    output logic       pwm_o
);

    localparam logic [4:0] CTRL_ADDR = BASE_ADDR + REG_CTRL;
    localparam logic [4:0] DUTY_ADDR = BASE_ADDR + REG_DUTY;

    ctrl_t             ctrl;
    ctrl_t             ctrl_new;
    logic [7:0]        duty;
    logic [7:0]        shadow;
    logic [STEP_W-1:0] step;
    sel_e              sel;
    logic              ctrl_wr;
    logic              duty_wr;
    logic              presc_chg;
    logic              tick;
    logic              period_end;
    logic              raw;

    always_comb begin
        sel = SEL_NONE;
        unique case (1'b1)
            (csr_a == CTRL_ADDR): sel = SEL_CTRL;
            (csr_a == DUTY_ADDR): sel = SEL_DUTY;
            default:              sel = SEL_NONE;
        endcase
    end

    always_comb begin
        csr_do = 8'h00;
        unique case (sel)
            SEL_CTRL: csr_do = ctrl;
            SEL_DUTY: csr_do = duty;
            default:  csr_do = 8'h00;
        endcase
    end

    assign ctrl_new  = ctrl_t'(csr_di & CTRL_MASK);
    assign ctrl_wr   = csr_we && (sel == SEL_CTRL);
    assign duty_wr   = csr_we && (sel == SEL_DUTY);
    assign presc_chg = ctrl_wr && (ctrl_new.presc != ctrl.presc);

    pwm_prescaler #(
        .DIV_BASE (DIV_BASE)
    ) u_presc (
        .clk   (clk),
        .rst_n (rst_n),
        .run   (ctrl.en),
        .clr   (presc_chg),
        .presc (ctrl.presc),
        .tick  (tick)
    );

    assign period_end = tick && (step == STEP_W'(STEPS - 1));

    // Duty 128..255 clamps to constant high
    assign raw = shadow[7] | (step < shadow[STEP_W-1:0]);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ctrl   <= '0;
            duty   <= '0;
            shadow <= '0;
            step   <= '0;
            pwm_o  <= 1'b0;
        end else begin
            if (ctrl_wr) begin
                ctrl <= ctrl_new;
            end
            if (duty_wr) begin
                duty <= csr_di;
            end

            // Shadow samples the pre-write DUTY, so a write in the
            // period-end cycle is deferred by one full period.
            if (!ctrl.en) begin
                step   <= '0;
                shadow <= duty;
            end else if (tick) begin
                step <= step + 1'b1;
                if (period_end) begin
                    shadow <= duty;
                end
            end

            pwm_o <= ctrl.en ? (raw ^ ctrl.inv) : ctrl.inv;
        end
    end

endmodule
